// File: rtl/mips_run_controller_pkg.sv
// Shared state encoding for the MIPS run controller and the debugger's status display.
package mips_run_controller_pkg;

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } run_state_e;

    function automatic logic is_active(input run_state_e s);
        return (s == S_RUN) || (s == S_STEP);
    endfunction

endpackage

// File: rtl/mips_run_controller_button_debouncer.sv
// Button conditioner: two-flop synchroniser, stable-sample debouncer, one-cycle pulse on the
// accepted rising edge. Press-to-pulse latency is DEBOUNCE_CYCLES+3 clocks.
module mips_run_controller_button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rstb,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_q;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    // NOTE: every register here is updated with <= so all flops sample pre-edge values, which is what makes the sync chain a chain.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_pulse   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts.
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
            r_level_q <= r_level;
            r_pulse   <= r_level & ~r_level_q;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/mips_run_controller.sv
// Run/halt/step sequencer for the multicycle MIPS core: owns core ena, one PC breakpoint,
// and cycle/instruction counters for the debugger display.
module mips_run_controller
    import mips_run_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit START_HALTED    = 1'b1,
    parameter int N               = 32
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         btn_run,
    input  logic         btn_step,
    input  logic         single_step_mode,
    input  logic         core_fetch,
    input  logic [N-1:0] PC,
    input  logic         bp_ena,
    input  logic [N-1:0] bp_addr,
    input  logic         cnt_clr,
    output logic         core_ena,
    output logic         single_step_active,
    output logic         halted,
    output logic         bp_hit,
    output logic [N-1:0] cycle_count,
    output logic [N-1:0] instr_count
);

    localparam run_state_e RESET_STATE = START_HALTED ? S_HALT : S_RUN;

    logic         w_run_pulse;
    logic         w_step_pulse;
    logic         w_bp_stop;
    logic         w_stop_now;
    logic         w_core_ena;
    logic         w_pulse_accepted;
    run_state_e   w_state_next;
    run_state_e   r_state;
    logic         r_first;
    logic         r_bp_hit;
    logic [N-1:0] r_cycle_count;
    logic [N-1:0] r_instr_count;

    mips_run_controller_button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run_db (
        .clk     (clk),
        .rstb    (rstb),
        .i_btn   (btn_run),
        .o_pulse (w_run_pulse)
    );

    mips_run_controller_button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk     (clk),
        .rstb    (rstb),
        .i_btn   (btn_step),
        .o_pulse (w_step_pulse)
    );

    // Stop decisions are combinational so the core is frozen in FETCH before executing it.
    assign w_bp_stop  = core_fetch & ~r_first & (r_state == S_RUN) & bp_ena & (PC == bp_addr);
    assign w_stop_now = core_fetch & ~r_first &
                        ((r_state == S_STEP) | w_bp_stop | ((r_state == S_RUN) & single_step_mode));
    assign w_core_ena = is_active(r_state) & ~w_stop_now;

    // NOTE: next state and the accept flag get defaults first so no path through the case infers a latch.
    always_comb begin
        w_state_next     = r_state;
        w_pulse_accepted = 1'b0;
        case (r_state)
            S_HALT: begin
                if (w_run_pulse && !single_step_mode) begin
                    w_state_next     = S_RUN;
                    w_pulse_accepted = 1'b1;
                end else if (w_step_pulse) begin
                    w_state_next     = S_STEP;
                    w_pulse_accepted = 1'b1;
                end
            end
            S_RUN: begin
                if (w_run_pulse) begin
                    w_state_next     = S_HALT;
                    w_pulse_accepted = 1'b1;
                end else if (w_stop_now) begin
                    w_state_next = S_HALT;
                end
            end
            S_STEP: begin
                if (w_stop_now) begin
                    w_state_next = S_HALT;
                end
            end
            default: w_state_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state  <= RESET_STATE;
            r_first  <= 1'b1;
            r_bp_hit <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_first  <= (w_state_next != r_state) && is_active(w_state_next);
            // A breakpoint halt wins over a simultaneous run press so the cause stays visible.
            if (w_bp_stop) begin
                r_bp_hit <= 1'b1;
            end else if (w_pulse_accepted) begin
                r_bp_hit <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else if (cnt_clr) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else if (w_core_ena) begin
            r_cycle_count <= r_cycle_count + 1'b1;
            if (core_fetch) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
        end
    end

    assign core_ena           = w_core_ena;
    assign single_step_active = (r_state == S_STEP);
    assign halted             = (r_state == S_HALT);
    assign bp_hit             = r_bp_hit;
    assign cycle_count        = r_cycle_count;
    assign instr_count        = r_instr_count;

endmodule
